// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared state enum, default depths and sample type for the MSDAP controller
package msdap_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_LOAD_RJ,
    ST_LOAD_COEFF,
    ST_WORKING,
    ST_CLEARING,
    ST_SLEEPING
  } msdap_state_e;

  localparam int MSDAP_RJ_DEPTH    = 16;
  localparam int MSDAP_COEFF_DEPTH = 512;
  localparam int MSDAP_DATA_DEPTH  = 256;
  localparam int MSDAP_ZERO_RUN    = 800;
  localparam int MSDAP_ADDR_W      = 9;

  typedef logic [15:0] sample_t;

endpackage

// File: rtl/msdap_zero_detect.sv
// rtl/msdap_zero_detect.sv - zero-run counter and sleep/wake decision (built only with MSDAP_SLEEP_EN)
module msdap_zero_detect
  import msdap_pkg::*;
#(
  parameter int ZERO_RUN = MSDAP_ZERO_RUN
) (
  input  logic        Sclk,
  input  logic        Reset_n,
  input  logic        clr,
  input  logic        sampleValid,
  input  logic [15:0] sampleL,
  input  logic [15:0] sampleR,
  input  logic        sleeping,
  output logic        enterSleep,
  output logic        wakeUp
);

  localparam int CNT_W = $clog2(ZERO_RUN + 1);

  logic [CNT_W-1:0] zeroCnt;
  sample_t          orWord;
  logic             isZero;

  assign orWord = sampleL | sampleR;
  assign isZero = (orWord == '0);

  // zeroCnt holds the zeros seen before this word, so ZERO_RUN-1 means this word completes the run
  assign enterSleep = sampleValid && isZero && !sleeping && (zeroCnt == CNT_W'(ZERO_RUN - 1));
  assign wakeUp     = sampleValid && !isZero && sleeping;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      zeroCnt <= '0;
    end else if (clr) begin
      zeroCnt <= '0;
    end else if (sampleValid) begin
      if (!isZero)
        zeroCnt <= '0;
      else if (zeroCnt != CNT_W'(ZERO_RUN))
        zeroCnt <= zeroCnt + 1'b1;
    end
  end

endmodule

// File: rtl/msdap_main_ctrl.sv
// rtl/msdap_main_ctrl.sv - MSDAP sequencing controller: memory sweep, Rj/coeff load, sample steering
// Zero-input sleep mode is built only when MSDAP_SLEEP_EN is defined.
module msdap_main_ctrl
  import msdap_pkg::*;
#(
  parameter int RJ_DEPTH    = MSDAP_RJ_DEPTH,
  parameter int COEFF_DEPTH = MSDAP_COEFF_DEPTH,
  parameter int DATA_DEPTH  = MSDAP_DATA_DEPTH,
  parameter int ZERO_RUN    = MSDAP_ZERO_RUN,
  parameter int ADDR_W      = MSDAP_ADDR_W
) (
  input  logic                          Sclk,
  input  logic                          Reset_n,
  input  logic                          Start,
  input  logic                          clear_req,
  input  logic                          word_valid,
  input  logic [15:0]                   word_l,
  input  logic [15:0]                   word_r,
  input  logic                          comp_busy,
  output logic                          InReady,
  output logic                          rj_we,
  output logic                          coeff_we,
  output logic                          data_we,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [15:0]                   wr_data_l,
  output logic [15:0]                   wr_data_r,
  output logic [$clog2(DATA_DEPTH)-1:0] data_ptr,
  output logic                          comp_start,
  output logic                          sleep,
  output logic                          overrun
);

  localparam int PTR_W = $clog2(DATA_DEPTH);

  msdap_state_e     state;
  logic [PTR_W:0]   sweepCnt;
  logic [ADDR_W-1:0] loadAddr;
  logic             compPend;
  logic             runState;
  logic             clearHit;
  logic             wordHit;
  logic [PTR_W-1:0] nextPtr;
  logic             enterSleep;
  logic             wakeUp;

  assign runState = (state == ST_WORKING) || (state == ST_SLEEPING);
  assign clearHit = clear_req && runState;
  assign wordHit  = word_valid && InReady && !Start && !clearHit;
  assign nextPtr  = data_ptr + 1'b1;

`ifdef MSDAP_SLEEP_EN
  logic sleepPend;

  msdap_zero_detect #(
    .ZERO_RUN (ZERO_RUN)
  ) u_zero_detect (
    .Sclk        (Sclk),
    .Reset_n     (Reset_n),
    .clr         (Start || clearHit),
    .sampleValid (wordHit && runState),
    .sampleL     (word_l),
    .sampleR     (word_r),
    .sleeping    (state == ST_SLEEPING),
    .enterSleep  (enterSleep),
    .wakeUp      (wakeUp)
  );
`else
  assign enterSleep = 1'b0;
  assign wakeUp     = 1'b0;
  assign sleep      = 1'b0;
`endif

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_INIT;
      sweepCnt   <= '0;
      loadAddr   <= '0;
      compPend   <= 1'b0;
      InReady    <= 1'b0;
      rj_we      <= 1'b0;
      coeff_we   <= 1'b0;
      data_we    <= 1'b0;
      wr_addr    <= '0;
      wr_data_l  <= '0;
      wr_data_r  <= '0;
      data_ptr   <= '0;
      comp_start <= 1'b0;
      overrun    <= 1'b0;
`ifdef MSDAP_SLEEP_EN
      sleep      <= 1'b0;
      sleepPend  <= 1'b0;
`endif
    end else begin
      rj_we      <= 1'b0;
      coeff_we   <= 1'b0;
      data_we    <= 1'b0;
      compPend   <= 1'b0;
      comp_start <= compPend;
`ifdef MSDAP_SLEEP_EN
      sleepPend  <= 1'b0;
      if (sleepPend) sleep <= 1'b1;
`endif
      if (Start) begin
        state      <= ST_INIT;
        sweepCnt   <= '0;
        loadAddr   <= '0;
        InReady    <= 1'b0;
        data_ptr   <= '0;
        comp_start <= 1'b0;
        overrun    <= 1'b0;
`ifdef MSDAP_SLEEP_EN
        sleep      <= 1'b0;
`endif
      end else if (clearHit) begin
        state    <= ST_CLEARING;
        sweepCnt <= '0;
        InReady  <= 1'b0;
`ifdef MSDAP_SLEEP_EN
        sleep    <= 1'b0;
`endif
      end else begin
        case (state)
          ST_INIT, ST_CLEARING: begin
            // one extra cycle after the last write keeps InReady off the final sweep beat
            if (sweepCnt == (PTR_W+1)'(DATA_DEPTH)) begin
              state    <= (state == ST_INIT) ? ST_LOAD_RJ : ST_WORKING;
              InReady  <= 1'b1;
              sweepCnt <= '0;
              data_ptr <= '1;
            end else begin
              data_we   <= 1'b1;
              wr_addr   <= ADDR_W'(sweepCnt);
              wr_data_l <= '0;
              wr_data_r <= '0;
              sweepCnt  <= sweepCnt + 1'b1;
            end
          end
          ST_LOAD_RJ, ST_LOAD_COEFF: begin
            if (wordHit) begin
              rj_we     <= (state == ST_LOAD_RJ);
              coeff_we  <= (state == ST_LOAD_COEFF);
              wr_addr   <= loadAddr;
              wr_data_l <= word_l;
              wr_data_r <= word_r;
              if ((state == ST_LOAD_RJ && loadAddr == ADDR_W'(RJ_DEPTH - 1)) ||
                  (state == ST_LOAD_COEFF && loadAddr == ADDR_W'(COEFF_DEPTH - 1))) begin
                state    <= (state == ST_LOAD_RJ) ? ST_LOAD_COEFF : ST_WORKING;
                loadAddr <= '0;
              end else begin
                loadAddr <= loadAddr + 1'b1;
              end
            end
          end
          ST_WORKING, ST_SLEEPING: begin
            if (wordHit) begin
              data_we   <= 1'b1;
              wr_addr   <= ADDR_W'(nextPtr);
              wr_data_l <= word_l;
              wr_data_r <= word_r;
              data_ptr  <= nextPtr;
              if (state == ST_WORKING || wakeUp) begin
                compPend <= 1'b1;
                if (comp_busy) overrun <= 1'b1;
              end
              if (enterSleep) state <= ST_SLEEPING;
              if (wakeUp)     state <= ST_WORKING;
`ifdef MSDAP_SLEEP_EN
              sleepPend <= enterSleep;
              if (wakeUp) sleep <= 1'b0;
`endif
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msdap_main_ctrl.sv
// tb/tb_msdap_main_ctrl.sv - scoreboard bench for msdap_main_ctrl (honours MSDAP_SLEEP_EN)
`timescale 1ns/1ps
module tb_msdap_main_ctrl;

  localparam int RJ_DEPTH    = 16;
  localparam int COEFF_DEPTH = 512;
  localparam int DATA_DEPTH  = 256;
  localparam int ZERO_RUN    = 800;
  localparam int ADDR_W      = 9;
  localparam int PTR_W       = $clog2(DATA_DEPTH);
`ifdef MSDAP_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  logic              Sclk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic              clear_req = 1'b0;
  logic              word_valid = 1'b0;
  logic [15:0]       word_l = '0;
  logic [15:0]       word_r = '0;
  logic              comp_busy = 1'b0;
  logic              InReady, rj_we, coeff_we, data_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data_l, wr_data_r;
  logic [PTR_W-1:0]  data_ptr;
  logic              comp_start, sleep, overrun;

  msdap_main_ctrl #(
    .RJ_DEPTH (RJ_DEPTH), .COEFF_DEPTH (COEFF_DEPTH), .DATA_DEPTH (DATA_DEPTH),
    .ZERO_RUN (ZERO_RUN), .ADDR_W (ADDR_W)
  ) dut (
    .Sclk (Sclk), .Reset_n (Reset_n), .Start (Start), .clear_req (clear_req),
    .word_valid (word_valid), .word_l (word_l), .word_r (word_r), .comp_busy (comp_busy),
    .InReady (InReady), .rj_we (rj_we), .coeff_we (coeff_we), .data_we (data_we),
    .wr_addr (wr_addr), .wr_data_l (wr_data_l), .wr_data_r (wr_data_r),
    .data_ptr (data_ptr), .comp_start (comp_start), .sleep (sleep), .overrun (overrun)
  );

  always #5 Sclk = ~Sclk;

  int cyc = 0;
  always @(posedge Sclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int addr;
    int l;
    int r;
    int cyc;
  } wr_ev_t;

  wr_ev_t wrQ[$];
  int     compQ[$];

  // reference model state: load progress, newest sample index, zero run, sleep, overrun
  int rjDone, coeffDone, mPtr, zeroRun;
  bit mAsleep, mOverrun, mReady;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushWr(input int kind, input int addr, input int l, input int r, input int c);
    wr_ev_t e;
    e.kind = kind; e.addr = addr; e.l = l; e.r = r; e.cyc = c;
    wrQ.push_back(e);
  endtask

  task automatic modelRestart();
    rjDone = 0; coeffDone = 0; mPtr = DATA_DEPTH - 1; zeroRun = 0;
    mAsleep = 0; mOverrun = 0; mReady = 0;
  endtask

  task automatic modelClear();
    mPtr = DATA_DEPTH - 1; zeroRun = 0; mAsleep = 0; mReady = 0;
  endtask

  task automatic expectSweep(input int base);
    for (int i = 0; i < DATA_DEPTH; i++) pushWr(3, i, 0, 0, base + 1 + i);
  endtask

  task automatic modelWord(input int l, input int r, input bit busy, input int t);
    bit zero;
    if (!mReady) return;
    if (rjDone < RJ_DEPTH) begin
      pushWr(1, rjDone, l, r, t);
      rjDone++;
    end else if (coeffDone < COEFF_DEPTH) begin
      pushWr(2, coeffDone, l, r, t);
      coeffDone++;
    end else begin
      mPtr = (mPtr + 1) % DATA_DEPTH;
      pushWr(3, mPtr, l, r, t);
      zero = (l == 0) && (r == 0);
      if (mAsleep) begin
        if (!zero) begin
          mAsleep = 0;
          zeroRun = 0;
          compQ.push_back(t + 1);
          if (busy) mOverrun = 1;
        end
      end else begin
        compQ.push_back(t + 1);
        if (busy) mOverrun = 1;
        zeroRun = zero ? zeroRun + 1 : 0;
        if (SLEEP_EN && zeroRun == ZERO_RUN) mAsleep = 1;
      end
    end
  endtask

  // returns at the negedge where the word's write strobe is visible (plus gap idle cycles)
  task automatic sendWord(input int l, input int r, input bit busy, input int gap);
    @(negedge Sclk);
    word_valid = 1'b1; word_l = 16'(l); word_r = 16'(r); comp_busy = busy;
    modelWord(l, r, busy, cyc + 1);
    @(negedge Sclk);
    word_valid = 1'b0; comp_busy = 1'b0;
    repeat (gap) @(negedge Sclk);
  endtask

  task automatic pulseCtrl(input bit isStart, output int base);
    @(negedge Sclk);
    if (isStart) Start = 1'b1; else clear_req = 1'b1;
    base = cyc + 1;
    if (isStart) modelRestart(); else modelClear();
    expectSweep(base);
    @(negedge Sclk);
    Start = 1'b0; clear_req = 1'b0;
  endtask

  task automatic waitReady(input int base, input string name);
    int n = 0;
    while (!InReady && n < 4 * DATA_DEPTH) begin
      @(negedge Sclk);
      n++;
    end
    check(name, cyc, base + DATA_DEPTH + 1);
    mReady = 1;
  endtask

  function automatic int rnd16(input bit nonZero);
    return nonZero ? int'($urandom_range(1, 65535)) : int'($urandom_range(0, 65535));
  endfunction

  wr_ev_t monExp;
  int     monKind;
  int     monC;

  always @(negedge Sclk) begin
    if (Reset_n) begin
      if (rj_we || coeff_we || data_we) begin
        checks++;
        monKind = rj_we ? 1 : (coeff_we ? 2 : 3);
        if (wrQ.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got kind=%0d addr=%0d at cyc %0d expected no write",
                   monKind, wr_addr, cyc);
        end else begin
          monExp = wrQ.pop_front();
          if ($countones({rj_we, coeff_we, data_we}) != 1 || monKind != monExp.kind ||
              int'(wr_addr) != monExp.addr || int'(wr_data_l) != monExp.l ||
              int'(wr_data_r) != monExp.r || cyc != monExp.cyc) begin
            errors++;
            $display("FAIL write_event: got we=%b addr=%0d l=%h r=%h cyc=%0d expected kind=%0d addr=%0d l=%h r=%h cyc=%0d",
                     {rj_we, coeff_we, data_we}, wr_addr, wr_data_l, wr_data_r, cyc,
                     monExp.kind, monExp.addr, monExp.l, monExp.r, monExp.cyc);
          end
        end
      end
      if (comp_start) begin
        checks++;
        if (compQ.size() == 0) begin
          errors++;
          $display("FAIL comp_start_unexpected: got pulse at cyc %0d expected none", cyc);
        end else begin
          monC = compQ.pop_front();
          if (cyc != monC) begin
            errors++;
            $display("FAIL comp_start_cycle: got cyc %0d expected cyc %0d", cyc, monC);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    modelRestart();
    repeat (3) @(negedge Sclk);
    check("reset_outputs", {InReady, rj_we, coeff_we, data_we, wr_addr, wr_data_l, wr_data_r,
                            data_ptr, comp_start, sleep, overrun}, 0);

    // reset sweep
    base = cyc;
    expectSweep(base);
    Reset_n = 1'b1;
    waitReady(base, "init_ready_cycle");

    // Rj and coefficient load, with a clear_req that must be ignored mid-load
    for (int i = 0; i < RJ_DEPTH; i++) begin
      if (i == 5) begin
        @(negedge Sclk); clear_req = 1'b1;
        @(negedge Sclk); clear_req = 1'b0;
        check("clear_ignored_in_load", InReady, mReady);
      end
      sendWord(rnd16(0), rnd16(0), 0, 1);
    end
    for (int i = 0; i < COEFF_DEPTH; i++) sendWord(rnd16(0), rnd16(0), 0, 1);
    check("ready_after_load", InReady, mReady);

    // wrap: 300 nonzero samples (right channel may be zero)
    for (int i = 0; i < 300; i++) sendWord(rnd16(1), rnd16(0), 0, $urandom_range(1, 2));
    check("data_ptr_wrap", data_ptr, mPtr);

    // zero run into sleep
    for (int i = 0; i < ZERO_RUN - 1; i++) sendWord(0, 0, 0, 1);
    sendWord(0, 0, 0, 0);
    check("sleep_before_rise", sleep, 0);
    @(negedge Sclk);
    check("sleep_rise", sleep, mAsleep);
    for (int i = 0; i < 10; i++) sendWord(0, 0, 0, 1);
    check("sleep_hold", sleep, mAsleep);
    sendWord(1, 0, 0, 0);
    check("sleep_fall", sleep, 0);
    @(negedge Sclk);

    // clear mid-run, with a word offered during the sweep that must be dropped
    for (int i = 0; i < 100; i++) sendWord(rnd16($urandom_range(0, 3) != 0), rnd16(0), 0, 1);
    pulseCtrl(0, base);
    check("clear_ready_low", InReady, mReady);
    sendWord(rnd16(1), rnd16(1), 0, 1);
    waitReady(base, "clear_ready_cycle");
    check("clear_sleep_low", sleep, mAsleep);
    sendWord(rnd16(1), rnd16(1), 0, 1);
    check("clear_data_ptr", data_ptr, mPtr);

    // overrun is sticky until Start
    sendWord(rnd16(1), rnd16(0), 1, 1);
    check("overrun_set", overrun, mOverrun);
    for (int i = 0; i < 3; i++) sendWord(rnd16(1), rnd16(0), 0, 1);
    check("overrun_sticky", overrun, mOverrun);
    pulseCtrl(1, base);
    check("start_overrun_clear", overrun, mOverrun);
    check("start_ready_low", InReady, mReady);
    waitReady(base, "start_ready_cycle");
    for (int i = 0; i < 4; i++) sendWord(rnd16(0), rnd16(0), 0, 1);

    repeat (5) @(negedge Sclk);
    check("write_queue_empty", wrQ.size(), 0);
    check("comp_queue_empty", compQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
